// File: rtl/player_mover.sv
// Player sprite sequencer: erases the 5x5 block, steps the position one pixel,
// then redraws it through the shared VGA plot port.
module player_mover #(
    parameter int         START_X = 5,
    parameter int         START_Y = 5,
    parameter int         SIZE    = 5,
    parameter int         MAX_X   = 159,
    parameter int         MAX_Y   = 119,
    parameter logic [5:0] PLAYER  = 6'b000011,
    parameter logic [5:0] BLANK   = 6'b000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] direction,
    input  logic       stop,
    input  logic       respawn,
    output logic [7:0] player_x,
    output logic [6:0] player_y,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [5:0] colour,
    output logic       plot,
    output logic       busy
);

    localparam int          CW      = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST  = CW'(SIZE - 1);
    localparam logic [7:0]  X_START = 8'(START_X);
    localparam logic [6:0]  Y_START = 7'(START_Y);
    localparam logic [7:0]  X_LIM   = 8'(MAX_X - SIZE + 1);
    localparam logic [6:0]  Y_LIM   = 7'(MAX_Y - SIZE + 1);

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        MOVE  = 2'd2,
        DRAW  = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] dx, dx_next;
    logic [CW-1:0] dy, dy_next;
    logic [7:0]    px_next;
    logic [6:0]    py_next;
    logic [3:0]    dir, dir_next;
    logic          rsp_pend, rsp_next;
    logic          one_hot;

    assign one_hot = (direction != 4'b0000) && ((direction & (direction - 4'd1)) == 4'b0000);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            player_x <= X_START;
            player_y <= Y_START;
            dx       <= '0;
            dy       <= '0;
            dir      <= '0;
            rsp_pend <= 1'b0;
        end else begin
            state    <= state_next;
            player_x <= px_next;
            player_y <= py_next;
            dx       <= dx_next;
            dy       <= dy_next;
            dir      <= dir_next;
            rsp_pend <= rsp_next;
        end
    end

    // A respawn arriving in the MOVE cycle itself survives to the next sequence.
    always_comb begin
        state_next = state;
        dx_next    = dx;
        dy_next    = dy;
        px_next    = player_x;
        py_next    = player_y;
        dir_next   = dir;
        rsp_next   = rsp_pend | respawn;

        case (state)
            IDLE: begin
                if (tick && (rsp_pend || respawn || one_hot)) begin
                    state_next = ERASE;
                    dir_next   = direction;
                    dx_next    = '0;
                    dy_next    = '0;
                end
            end
            ERASE, DRAW: begin
                if (dx == LAST) begin
                    dx_next = '0;
                    if (dy == LAST) begin
                        dy_next    = '0;
                        state_next = (state == ERASE) ? MOVE : IDLE;
                    end else begin
                        dy_next = dy + 1'b1;
                    end
                end else begin
                    dx_next = dx + 1'b1;
                end
            end
            MOVE: begin
                state_next = DRAW;
                if (rsp_pend) begin
                    px_next  = X_START;
                    py_next  = Y_START;
                    rsp_next = respawn;
                end else if (!stop) begin
                    case (dir)
                        DIR_UP:    if (player_y > 7'd0)  py_next = player_y - 7'd1;
                        DIR_DOWN:  if (player_y < Y_LIM) py_next = player_y + 7'd1;
                        DIR_LEFT:  if (player_x > 8'd0)  px_next = player_x - 8'd1;
                        DIR_RIGHT: if (player_x < X_LIM) px_next = player_x + 8'd1;
                        default:   ;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        x_out  = '0;
        y_out  = '0;
        colour = BLANK;
        plot   = 1'b0;
        if (state == ERASE || state == DRAW) begin
            plot   = 1'b1;
            x_out  = player_x + 8'(dx);
            y_out  = player_y + 7'(dy);
            colour = (state == DRAW) ? PLAYER : BLANK;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover: expected plot pixels go into a scoreboard
// queue and an independent monitor compares every plotted pixel.
`timescale 1ns/1ps
module tb_player_mover;

    localparam logic [3:0] UP    = 4'b1000;
    localparam logic [3:0] DOWN  = 4'b0100;
    localparam logic [3:0] LEFT  = 4'b0010;
    localparam logic [3:0] RIGHT = 4'b0001;
    localparam int C_PLAYER = 3;
    localparam int C_BLANK  = 0;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] direction = 4'b0000;
    logic       stop = 1'b0;
    logic       respawn = 1'b0;
    logic [7:0] player_x;
    logic [6:0] player_y;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [5:0] colour;
    logic       plot;
    logic       busy;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cur_x = 5;
    int   cur_y = 5;

    player_mover dut (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick),
        .direction (direction),
        .stop      (stop),
        .respawn   (respawn),
        .player_x  (player_x),
        .player_y  (player_y),
        .x_out     (x_out),
        .y_out     (y_out),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_block(input int x0, input int y0, input int c);
        for (int r = 0; r < 5; r++)
            for (int k = 0; k < 5; k++)
                sb.push_back('{x0 + k, y0 + r, c});
    endtask

    // Monitor: every plotted pixel must match the head of the scoreboard.
    always @(negedge clock) begin
        if (!reset && plot) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL unexpected_plot: got (%0d,%0d,c%0d) expected none", x_out, y_out, colour);
            end else begin
                pix_t e;
                e = sb.pop_front();
                check_output("plot_x", int'(x_out), e.x);
                check_output("plot_y", int'(y_out), e.y);
                check_output("plot_colour", int'(colour), e.c);
            end
        end
    end

    task automatic apply_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        sb.delete();
        repeat (2) @(posedge clock);
        #1;
        check_output("rst_player_x", int'(player_x), 5);
        check_output("rst_player_y", int'(player_y), 5);
        check_output("rst_plot", int'(plot), 0);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_x_out", int'(x_out), 0);
        check_output("rst_y_out", int'(y_out), 0);
        check_output("rst_colour", int'(colour), C_BLANK);
        reset = 1'b0;
        cur_x = 5;
        cur_y = 5;
    endtask

    // One full move sequence; cycle 0 is the tick cycle.
    task automatic apply_stimulus(input logic [3:0] d, input logic rsp, input logic stop_mv,
                                  input logic extra, input int rsp_at, input int ex, input int ey);
        push_block(cur_x, cur_y, C_BLANK);
        push_block(ex, ey, C_PLAYER);
        @(posedge clock); #1;
        tick      = 1'b1;
        direction = d;
        respawn   = rsp;
        for (int c = 1; c <= 52; c++) begin
            @(posedge clock); #1;
            tick    = 1'b0;
            respawn = 1'b0;
            stop    = 1'b0;
            if (c == 1) direction = ~d;
            if (extra && (c == 3 || c == 30)) tick = 1'b1;
            if (c == rsp_at) respawn = 1'b1;
            if (c == 26) begin
                stop = stop_mv;
                check_output("move_old_x", int'(player_x), cur_x);
                check_output("move_old_y", int'(player_y), cur_y);
                check_output("move_plot", int'(plot), 0);
            end
            if (c == 27) begin
                check_output("new_x", int'(player_x), ex);
                check_output("new_y", int'(player_y), ey);
            end
            check_output("busy", int'(busy), int'(c <= 51));
        end
        check_output("sb_drained", sb.size(), 0);
        cur_x = ex;
        cur_y = ey;
    endtask

    task automatic apply_idle_tick(input logic [3:0] d);
        @(posedge clock); #1;
        tick      = 1'b1;
        direction = d;
        @(posedge clock); #1;
        tick = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clock); #1;
            check_output("ignored_busy", int'(busy), 0);
        end
        check_output("ignored_x", int'(player_x), cur_x);
        check_output("ignored_y", int'(player_y), cur_y);
    endtask

    task automatic apply_reset_mid_erase();
        push_block(cur_x, cur_y, C_BLANK);
        @(posedge clock); #1;
        tick      = 1'b1;
        direction = LEFT;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clock); #1;
            tick = 1'b0;
            if (c == 12) begin
                check_output("pre_reset_busy", int'(busy), 1);
                reset = 1'b1;
                sb.delete();
            end
        end
        @(negedge clock);
        check_output("abort_plot", int'(plot), 0);
        check_output("abort_busy", int'(busy), 0);
        check_output("abort_x", int'(player_x), 5);
        check_output("abort_y", int'(player_y), 5);
        @(posedge clock); #1;
        reset = 1'b0;
        cur_x = 5;
        cur_y = 5;
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        apply_reset();

        $display("[TB] step right from reset");
        apply_stimulus(RIGHT, 1'b0, 1'b0, 1'b0, 0, 6, 5);

        $display("[TB] stop held in MOVE");
        apply_reset();
        apply_stimulus(UP, 1'b0, 1'b1, 1'b0, 0, 5, 5);

        $display("[TB] clamp at top and right edges");
        for (int i = 0; i < 5; i++) apply_stimulus(UP, 1'b0, 1'b0, 1'b0, 0, cur_x, cur_y - 1);
        apply_stimulus(UP, 1'b0, 1'b0, 1'b0, 0, 5, 0);
        for (int i = 0; i < 150; i++) apply_stimulus(RIGHT, 1'b0, 1'b0, 1'b0, 0, cur_x + 1, cur_y);
        apply_stimulus(RIGHT, 1'b0, 1'b0, 1'b0, 0, 155, 0);

        $display("[TB] respawn during draw");
        apply_reset();
        for (int i = 0; i < 35; i++) apply_stimulus(RIGHT, 1'b0, 1'b0, 1'b0, 0, cur_x + 1, cur_y);
        for (int i = 0; i < 34; i++) apply_stimulus(DOWN, 1'b0, 1'b0, 1'b0, 0, cur_x, cur_y + 1);
        apply_stimulus(DOWN, 1'b0, 1'b0, 1'b0, 36, 40, 40);
        apply_stimulus(DOWN, 1'b0, 1'b0, 1'b0, 0, 5, 5);

        $display("[TB] extra ticks and multi-hot direction");
        apply_stimulus(RIGHT, 1'b0, 1'b0, 1'b1, 0, 6, 5);
        apply_idle_tick(4'b0011);
        apply_idle_tick(4'b0000);

        $display("[TB] respawn with tick in IDLE");
        apply_stimulus(RIGHT, 1'b1, 1'b0, 1'b0, 0, 5, 5);
        apply_stimulus(RIGHT, 1'b0, 1'b0, 1'b0, 0, 6, 5);

        $display("[TB] reset during erase");
        apply_reset_mid_erase();
        apply_stimulus(DOWN, 1'b0, 1'b0, 1'b0, 0, 5, 6);

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
